// File: rtl/reset_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reset_seq_pkg
// Description : Shared types and constants for the reset sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package reset_seq_pkg;

    localparam int c_restart_w = 8;

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/reset_debounce.sv
`default_nettype none
// ============================================================================
// Module      : reset_debounce
// Description : Two-flop synchroniser plus consecutive-sample debouncer.
// Revision    : 1.0 - initial release
// ============================================================================
module reset_debounce #(
    parameter int DEBOUNCE = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic out
);

    localparam int c_cnt_w = $clog2(DEBOUNCE + 1);

    logic               r_meta;
    logic               r_sync;
    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_cnt  <= '0;
            out    <= 1'b0;
        end else begin
            r_meta <= in;
            r_sync <= r_meta;
            // Any sample agreeing with the current output restarts the run.
            if (r_sync == out) begin
                r_cnt <= '0;
            end else if (r_cnt == c_cnt_w'(DEBOUNCE - 1)) begin
                out   <= ~out;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : reset_sequencer
// Description : Stretched, staggered multi-domain reset release with
//               debounced button restart and saturating restart counter.
// Revision    : 1.0 - initial release
// ============================================================================
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int                   CHANNELS  = 2,
    parameter int                   STRETCH   = 8,
    parameter int                   STAGGER   = 4,
    parameter int                   BTN_WIDTH = 7,
    parameter logic [BTN_WIDTH-1:0] BTN_MASK  = 7'b0000001,
    parameter int                   DEBOUNCE  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [BTN_WIDTH-1:0]   btn,
    output logic [CHANNELS-1:0]    rst_out,
    output logic                   ready,
    output logic [c_restart_w-1:0] restart_count
);

    localparam int c_cnt_w = $clog2(STRETCH + CHANNELS * STAGGER + 1);

    logic                w_req_raw;
    logic                w_req_db;
    logic [CHANNELS-1:0] w_drop;
    state_t              r_state;
    logic [c_cnt_w-1:0]  r_cnt;
    logic                r_req_db_q;

    assign w_req_raw = |(btn & BTN_MASK);

    reset_debounce #(
        .DEBOUNCE (DEBOUNCE)
    ) u_debounce (
        .clk   (clk),
        .reset (reset),
        .in    (w_req_raw),
        .out   (w_req_db)
    );

    // r_cnt runs continuously through HOLD and RELEASE, so each channel
    // releases when the elapsed count hits its fixed offset.
    for (genvar i = 0; i < CHANNELS; i++) begin : g_drop
        assign w_drop[i] = (r_cnt == c_cnt_w'(STRETCH - 1 + i * STAGGER));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rst_out       <= '1;
            ready         <= 1'b0;
            restart_count <= '0;
            r_state       <= HOLD;
            r_cnt         <= '0;
            r_req_db_q    <= 1'b0;
        end else begin
            r_req_db_q <= w_req_db;
            if (w_req_db && !r_req_db_q && (restart_count != '1)) begin
                restart_count <= restart_count + 1'b1;
            end

            if (w_req_db) begin
                rst_out <= '1;
                ready   <= 1'b0;
                r_state <= HOLD;
                r_cnt   <= '0;
            end else begin
                case (r_state)
                    HOLD, RELEASE: begin
                        rst_out <= rst_out & ~w_drop;
                        r_cnt   <= r_cnt + 1'b1;
                        if (w_drop[CHANNELS-1]) begin
                            ready   <= 1'b1;
                            r_state <= RUN;
                        end else if (w_drop[0]) begin
                            r_state <= RELEASE;
                        end
                    end
                    RUN: begin
                    end
                    default: r_state <= HOLD;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_reset_sequencer
// Description : Directed self-checking bench for reset_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] btn_a, btn_b, btn_c;
    logic [1:0] rst_a, rst_c;
    logic [2:0] rst_b;
    logic       rdy_a, rdy_b, rdy_c;
    logic [7:0] cnt_a, cnt_b, cnt_c;
    int         edge_n;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    // Edge 1 is the first posedge after reset deasserts.
    always @(posedge clk or posedge reset) begin
        if (reset) edge_n <= 0;
        else       edge_n <= edge_n + 1;
    end

    reset_sequencer u_dut_a (
        .clk(clk), .reset(reset), .btn(btn_a),
        .rst_out(rst_a), .ready(rdy_a), .restart_count(cnt_a)
    );

    reset_sequencer #(.CHANNELS(3), .STRETCH(1), .STAGGER(0)) u_dut_b (
        .clk(clk), .reset(reset), .btn(btn_b),
        .rst_out(rst_b), .ready(rdy_b), .restart_count(cnt_b)
    );

    reset_sequencer #(.DEBOUNCE(2)) u_dut_c (
        .clk(clk), .reset(reset), .btn(btn_c),
        .rst_out(rst_c), .ready(rdy_c), .restart_count(cnt_c)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, edge_n);
        end
    endtask

    task automatic goto_edge(input int n);
        while (edge_n < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_c(input logic [1:0] r, input logic y, input logic [7:0] c);
        check("c_rst", 32'(rst_c), 32'(r));
        check("c_rdy", 32'(rdy_c), 32'(y));
        check("c_cnt", 32'(cnt_c), 32'(c));
    endtask

    task automatic press_c();
        btn_c = 7'b0000001;
        goto_edge(edge_n + 6);
        btn_c = 7'b0000000;
        goto_edge(edge_n + 6);
    endtask

    initial begin
        reset = 1'b1;
        btn_a = '0;
        btn_b = '0;
        btn_c = '0;
        #2;
        check("rst_a_reset", 32'(rst_a), 32'h3);
        check("rdy_a_reset", 32'(rdy_a), 32'h0);
        check("cnt_a_reset", 32'(cnt_a), 32'h0);
        check("rst_b_reset", 32'(rst_b), 32'h7);
        check("rdy_b_reset", 32'(rdy_b), 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_b_edge0", 32'(rst_b), 32'h7);
        check("rdy_b_edge0", 32'(rdy_b), 32'h0);
        check("rst_a_edge0", 32'(rst_a), 32'h3);

        // Power-on sequence
        for (int e = 1; e <= 12; e++) begin
            goto_edge(e);
            check("a_pwr_rst", 32'(rst_a), (e < 8) ? 32'h3 : (e < 12) ? 32'h2 : 32'h0);
            check("a_pwr_rdy", 32'(rdy_a), (e >= 12) ? 32'h1 : 32'h0);
            check("b_pwr_rst", 32'(rst_b), 32'h0);
            check("b_pwr_rdy", 32'(rdy_b), 32'h1);
        end
        check("a_pwr_cnt", 32'(cnt_a), 32'h0);

        // Button press on A: high before edge 100 for 40 cycles
        goto_edge(99);
        btn_a = 7'b0000001;
        goto_edge(117);
        check("a_btn_pre_rst", 32'(rst_a), 32'h0);
        check("a_btn_pre_rdy", 32'(rdy_a), 32'h1);
        check("a_btn_pre_cnt", 32'(cnt_a), 32'h0);
        goto_edge(118);
        check("a_btn_rst", 32'(rst_a), 32'h3);
        check("a_btn_rdy", 32'(rdy_a), 32'h0);
        check("a_btn_cnt", 32'(cnt_a), 32'h1);
        goto_edge(139);
        btn_a = 7'b0000000;
        goto_edge(164);
        check("a_rel_164", 32'(rst_a), 32'h3);
        goto_edge(165);
        check("a_rel_165", 32'(rst_a), 32'h2);
        check("a_rel_165_rdy", 32'(rdy_a), 32'h0);
        goto_edge(168);
        check("a_rel_168", 32'(rst_a), 32'h2);
        goto_edge(169);
        check("a_rel_169", 32'(rst_a), 32'h0);
        check("a_rel_169_rdy", 32'(rdy_a), 32'h1);
        check("a_rel_169_cnt", 32'(cnt_a), 32'h1);

        // Glitches of 1, 5, 15 cycles and a long masked press: no effect
        for (int e = 170; e <= 400; e++) begin
            goto_edge(e);
            check("a_glitch_rst", 32'(rst_a), 32'h0);
            check("a_glitch_rdy", 32'(rdy_a), 32'h1);
            check("a_glitch_cnt", 32'(cnt_a), 32'h1);
            btn_a[0] = (e == 200) || (e >= 220 && e < 225) || (e >= 240 && e < 255);
            btn_a[3] = (e >= 280 && e < 380);
        end

        // Mid-RELEASE restart on C (DEBOUNCE=2)
        goto_edge(410);
        btn_c = 7'b0000001;
        goto_edge(414);
        check_c(2'b00, 1'b1, 8'd0);
        goto_edge(415);
        check_c(2'b11, 1'b0, 8'd1);
        goto_edge(420);
        btn_c = 7'b0000000;
        goto_edge(429);
        btn_c = 7'b0000001;
        goto_edge(431);
        check_c(2'b11, 1'b0, 8'd1);
        goto_edge(432);
        check_c(2'b10, 1'b0, 8'd1);
        goto_edge(433);
        check_c(2'b10, 1'b0, 8'd1);
        goto_edge(434);
        check_c(2'b11, 1'b0, 8'd2);
        goto_edge(436);
        check_c(2'b11, 1'b0, 8'd2);
        goto_edge(439);
        btn_c = 7'b0000000;
        goto_edge(450);
        check_c(2'b11, 1'b0, 8'd2);
        goto_edge(451);
        check_c(2'b10, 1'b0, 8'd2);
        goto_edge(454);
        check_c(2'b10, 1'b0, 8'd2);
        goto_edge(455);
        check_c(2'b00, 1'b1, 8'd2);

        // Saturation of restart_count
        for (int p = 0; p < 252; p++) press_c();
        goto_edge(edge_n + 10);
        check("c_cnt_254", 32'(cnt_c), 32'd254);
        press_c();
        goto_edge(edge_n + 10);
        check("c_cnt_255", 32'(cnt_c), 32'd255);
        for (int p = 0; p < 45; p++) press_c();
        goto_edge(edge_n + 30);
        check_c(2'b00, 1'b1, 8'd255);
        check("a_pre_async_cnt", 32'(cnt_a), 32'h1);
        check("a_pre_async_rdy", 32'(rdy_a), 32'h1);

        // Async reset between edges
        #3;
        reset = 1'b1;
        #1;
        check("a_async_rst", 32'(rst_a), 32'h3);
        check("a_async_rdy", 32'(rdy_a), 32'h0);
        check("a_async_cnt", 32'(cnt_a), 32'h0);
        check_c(2'b11, 1'b0, 8'd0);
        check("b_async_rst", 32'(rst_b), 32'h7);
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
